// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage: field split, operand bypass, busy scoreboard and a
// registered micro-op handed to the ALU over a valid/ready handshake.
module decode_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              ex_ready,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [DATA_W-1:0] imm,
    output logic              use_imm,
    output logic              reg_write,
    output logic [REG_AW-1:0] dest,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              branch,
    output logic              illegal
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rd_f;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] imm_zx;
    logic              unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign rs_addr      = instr[25:21];
    assign rt_addr      = instr[20:16];
    assign rd_f         = instr[15:11];
    assign imm_sx       = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign imm_zx       = {{(DATA_W-16){1'b0}}, instr[15:0]};
    assign unused_shamt = ^instr[10:6];

    logic [2:0]        dec_op;
    logic              dec_use_imm;
    logic              dec_rw_raw;
    logic              dec_rw;
    logic [REG_AW-1:0] dec_dest;
    logic              dec_mem_rd;
    logic              dec_mem_wr;
    logic              dec_branch;
    logic              dec_illegal;
    logic [DATA_W-1:0] dec_imm;
    logic              use_rs;
    logic              use_rt;

    always_comb begin
        dec_op      = ALU_NOP;
        dec_use_imm = 1'b0;
        dec_rw_raw  = 1'b0;
        dec_dest    = '0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        dec_imm     = imm_sx;
        use_rs      = 1'b1;
        use_rt      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rt     = 1'b1;
                dec_rw_raw = 1'b1;
                dec_dest   = rd_f;
                case (funct)
                    FN_ADD:  dec_op = ALU_ADD;
                    FN_SUB:  dec_op = ALU_SUB;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_SLT:  dec_op = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_op      = ALU_ADD;
                dec_use_imm = 1'b1;
                dec_rw_raw  = 1'b1;
                dec_dest    = rt_addr;
            end
            OP_ANDI: begin
                dec_op      = ALU_AND;
                dec_imm     = imm_zx;
                dec_use_imm = 1'b1;
                dec_rw_raw  = 1'b1;
                dec_dest    = rt_addr;
            end
            OP_ORI: begin
                dec_op      = ALU_OR;
                dec_imm     = imm_zx;
                dec_use_imm = 1'b1;
                dec_rw_raw  = 1'b1;
                dec_dest    = rt_addr;
            end
            OP_LW: begin
                dec_op      = ALU_ADD;
                dec_use_imm = 1'b1;
                dec_rw_raw  = 1'b1;
                dec_dest    = rt_addr;
                dec_mem_rd  = 1'b1;
            end
            OP_SW: begin
                dec_op      = ALU_ADD;
                dec_use_imm = 1'b1;
                dec_mem_wr  = 1'b1;
                use_rt      = 1'b1;
            end
            OP_BEQ: begin
                dec_op     = ALU_SUB;
                dec_branch = 1'b1;
                use_rt     = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal words still issue, but as an inert NOP that reads and writes nothing.
        if (dec_illegal) begin
            dec_op     = ALU_NOP;
            dec_rw_raw = 1'b0;
            dec_dest   = '0;
            use_rs     = 1'b0;
            use_rt     = 1'b0;
        end
    end

    assign dec_rw = dec_rw_raw && (dec_dest != '0);

    logic              bypass_rs;
    logic              bypass_rt;
    logic [DATA_W-1:0] opa_d;
    logic [DATA_W-1:0] opb_d;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              hazard;
    logic              accept;

    assign bypass_rs = wb_valid && (wb_dest == rs_addr);
    assign bypass_rt = wb_valid && (wb_dest == rt_addr);

    always_comb begin
        opa_d = rd_data1;
        opb_d = rd_data2;
        if (rs_addr == '0)  opa_d = '0;
        else if (bypass_rs) opa_d = wb_data;
        if (rt_addr == '0)  opb_d = '0;
        else if (bypass_rt) opb_d = wb_data;
    end

    // A same-cycle write-back of the source resolves the dependency through the bypass.
    assign hazard = (use_rs && busy_q[rs_addr] && !bypass_rs) ||
                    (use_rt && busy_q[rt_addr] && !bypass_rt);

    logic out_valid_q;

    assign instr_ready = (!out_valid_q || ex_ready) && !hazard && !reset;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_dest] = 1'b0;
        if (accept && dec_rw) busy_d[dec_dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] imm_q;
    logic              use_imm_q;
    logic              reg_write_q;
    logic [REG_AW-1:0] dest_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              branch_q;
    logic              illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            dest_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                alu_op_q    <= dec_op;
                opa_q       <= opa_d;
                opb_q       <= opb_d;
                imm_q       <= dec_imm;
                use_imm_q   <= dec_use_imm;
                reg_write_q <= dec_rw;
                dest_q      <= dec_dest;
                mem_rd_q    <= dec_mem_rd;
                mem_wr_q    <= dec_mem_wr;
                branch_q    <= dec_branch;
                illegal_q   <= dec_illegal;
            end else if (ex_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = alu_op_q;
    assign opa       = opa_q;
    assign opb       = opb_q;
    assign imm       = imm_q;
    assign use_imm   = use_imm_q;
    assign reg_write = reg_write_q;
    assign dest      = dest_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign branch    = branch_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios followed by random traffic,
// all compared against an instruction-level reference model.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        ex_ready;
    logic [2:0]  alu_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic [4:0]  dest;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        illegal;

    decode_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_data(wb_data), .out_valid(out_valid),
        .ex_ready(ex_ready), .alu_op(alu_op), .opa(opa), .opb(opb), .imm(imm),
        .use_imm(use_imm), .reg_write(reg_write), .dest(dest), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .branch(branch), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        ui;
        logic        rw;
        logic [4:0]  dest;
        logic        mr;
        logic        mw;
        logic        br;
        logic        il;
    } uop_t;

    int          n_checks = 0;
    int          n_errors = 0;
    uop_t        exp_q = '0;
    logic [31:0] busy_m = '0;
    logic        last_rdy;
    logic        last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s got=0x%08h want=0x%08h t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Instruction-level meaning of each opcode, independent of operand values.
    function automatic void ref_decode(input logic [31:0] ins, output uop_t u,
                                       output logic urs, output logic urt);
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        u = '0;
        u.vld = 1'b1;
        u.imm = {{16{ins[15]}}, ins[15:0]};
        urs = 1'b1;
        urt = 1'b0;
        case (opc)
            6'h00: begin
                urt = 1'b1; u.rw = 1'b1; u.dest = ins[15:11];
                if      (fn == 6'h20) u.op = 3'd1;
                else if (fn == 6'h22) u.op = 3'd2;
                else if (fn == 6'h24) u.op = 3'd3;
                else if (fn == 6'h25) u.op = 3'd4;
                else if (fn == 6'h2A) u.op = 3'd5;
                else u.il = 1'b1;
            end
            6'h08: begin u.op = 3'd1; u.ui = 1'b1; u.rw = 1'b1; u.dest = ins[20:16]; end
            6'h0C: begin u.op = 3'd3; u.ui = 1'b1; u.rw = 1'b1; u.dest = ins[20:16];
                         u.imm = {16'h0, ins[15:0]}; end
            6'h0D: begin u.op = 3'd4; u.ui = 1'b1; u.rw = 1'b1; u.dest = ins[20:16];
                         u.imm = {16'h0, ins[15:0]}; end
            6'h23: begin u.op = 3'd1; u.ui = 1'b1; u.rw = 1'b1; u.dest = ins[20:16]; u.mr = 1'b1; end
            6'h2B: begin u.op = 3'd1; u.ui = 1'b1; u.mw = 1'b1; urt = 1'b1; end
            6'h04: begin u.op = 3'd2; u.br = 1'b1; urt = 1'b1; end
            default: u.il = 1'b1;
        endcase
        if (u.il) begin
            u.op = 3'd0; u.rw = 1'b0; u.dest = 5'd0; urs = 1'b0; urt = 1'b0;
        end
        if (u.dest == 5'd0) u.rw = 1'b0;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic [31:0] rf,
                                                input logic wbv, input logic [4:0] wbd,
                                                input logic [31:0] wbdat);
        if (src == 5'd0) return 32'd0;
        if (wbv && wbd == src) return wbdat;
        return rf;
    endfunction

    task automatic step(input logic [31:0] ins, input logic iv, input logic exr,
                        input logic wbv, input logic [4:0] wbd, input logic [31:0] wbdat,
                        input logic rst_in);
        uop_t       nu;
        logic       urs, urt, hz, rdy;
        logic [4:0] s1, s2;
        @(negedge clk);
        reset = rst_in; instr = ins; instr_valid = iv; ex_ready = exr;
        wb_valid = wbv; wb_dest = wbd; wb_data = wbdat;
        rd_data1 = $urandom; rd_data2 = $urandom;
        #1;
        s1 = ins[25:21];
        s2 = ins[20:16];
        ref_decode(ins, nu, urs, urt);
        nu.a = ref_operand(s1, rd_data1, wbv, wbd, wbdat);
        nu.b = ref_operand(s2, rd_data2, wbv, wbd, wbdat);
        hz  = (urs && busy_m[s1] && !(wbv && wbd == s1)) ||
              (urt && busy_m[s2] && !(wbv && wbd == s2));
        rdy = (!exp_q.vld || exr) && !hz && !rst_in;
        chk("instr_ready", 32'(instr_ready), 32'(rdy));
        chk("rs_addr", 32'(rs_addr), 32'(s1));
        chk("rt_addr", 32'(rt_addr), 32'(s2));
        last_rdy = rdy;
        last_acc = iv && rdy;
        if (rst_in) begin
            exp_q  = '0;
            busy_m = '0;
        end else begin
            if (wbv) busy_m[wbd] = 1'b0;
            if (last_acc) begin
                exp_q = nu;
                if (nu.rw) busy_m[nu.dest] = 1'b1;
            end else if (exr) begin
                exp_q.vld = 1'b0;
            end
            busy_m[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_q.vld));
        chk("alu_op", 32'(alu_op), 32'(exp_q.op));
        chk("opa", opa, exp_q.a);
        chk("opb", opb, exp_q.b);
        chk("imm", imm, exp_q.imm);
        chk("use_imm", 32'(use_imm), 32'(exp_q.ui));
        chk("reg_write", 32'(reg_write), 32'(exp_q.rw));
        chk("dest", 32'(dest), 32'(exp_q.dest));
        chk("mem_rd", 32'(mem_rd), 32'(exp_q.mr));
        chk("mem_wr", 32'(mem_wr), 32'(exp_q.mw));
        chk("branch", 32'(branch), 32'(exp_q.br));
        chk("illegal", 32'(illegal), 32'(exp_q.il));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  ra, rb, rc;
        logic [15:0] im;
        logic [5:0]  fns [6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
        rc = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        case ($urandom_range(0, 8))
            0: return {6'h00, ra, rb, rc, 5'd0, fns[$urandom_range(0, 5)]};
            1: return {6'h08, ra, rb, im};
            2: return {6'h0C, ra, rb, im};
            3: return {6'h0D, ra, rb, im};
            4: return {6'h23, ra, rb, im};
            5: return {6'h2B, ra, rb, im};
            6: return {6'h04, ra, rb, im};
            7: return {6'h3F, ra, rb, im};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; instr = '0; instr_valid = 1'b0; ex_ready = 1'b0;
        wb_valid = 1'b0; wb_dest = '0; wb_data = '0; rd_data1 = '0; rd_data2 = '0;

        step(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        step(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);

        // addi $8,$0,-5
        step(32'h2008FFFB, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_op", 32'(alu_op), 32'd1);
        chk("addi_imm", imm, 32'hFFFFFFFB);
        chk("addi_dest", 32'(dest), 32'd8);
        chk("addi_rw", 32'(reg_write), 32'd1);

        // add $9,$8,$8 stalls until $8 is written back, then takes the bypass
        step(32'h01084820, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("raw_stall", 32'(last_rdy), 32'd0);
        step(32'h01084820, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("raw_stall2", 32'(last_rdy), 32'd0);
        step(32'h01084820, 1'b1, 1'b1, 1'b1, 5'd8, 32'd7, 1'b0);
        chk("raw_accept", 32'(last_acc), 32'd1);
        chk("bypass_opa", opa, 32'd7);
        chk("bypass_opb", opb, 32'd7);

        // ori $10,$0,0x8000 ; lw $11,4($8)
        step(32'h340A8000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("ori_imm", imm, 32'h00008000);
        step(32'h8D0B0004, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("lw_memrd", 32'(mem_rd), 32'd1);
        chk("lw_imm", imm, 32'd4);
        chk("lw_dest", 32'(dest), 32'd11);

        // back-pressure: lw stays on the output while sub $12,$1,$2 waits
        for (int i = 0; i < 3; i++) begin
            step(32'h00226022, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            chk("hold_ready", 32'(last_rdy), 32'd0);
            chk("hold_dest", 32'(dest), 32'd11);
        end
        step(32'h00226022, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("release_dest", 32'(dest), 32'd12);
        step(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // illegal opcode, then a write to $0
        step(32'hFC000000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_rw", 32'(reg_write), 32'd0);
        step(32'h00220020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("r0_rw", 32'(reg_write), 32'd0);

        // reset in the middle of a hold discards the micro-op and clears busy $12
        step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        step(32'h018C6820, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("rst_busy_clear", 32'(last_rdy), 32'd1);

        for (int i = 0; i < 800; i++) begin
            step(rand_instr(), 1'($urandom_range(0, 99) < 75),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 40),
                 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction decode/issue stage sitting directly upstream of the Registers block and downstream of instruction fetch.
- Splits a 32-bit MIPS instruction into fields and drives the register-file read addresses.
- Forms operands, with bypass of the write-back value, and issues a registered micro-op to the ALU stage over a valid/ready handshake.
- Keeps a per-register busy scoreboard so a consumer never issues ahead of its producer's write-back.

Parameters:
DATA_W, 32, datapath and instruction width
REG_AW, 5, register address width (32 architectural registers)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instr  in  DATA_W  instruction word from fetch
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  stage accepts instr this cycle
rs_addr  out  REG_AW  register-file read address 1, equal to instr[25:21]
rt_addr  out  REG_AW  register-file read address 2, equal to instr[20:16]
rd_data1  in  DATA_W  register-file data for rs_addr
rd_data2  in  DATA_W  register-file data for rt_addr
wb_valid  in  1  write-back occurring this cycle
wb_dest  in  REG_AW  write-back destination
wb_data  in  DATA_W  write-back value
out_valid  out  1  issued micro-op valid
ex_ready  in  1  ALU stage accepts micro-op
alu_op  out  3  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT
opa  out  DATA_W  operand A (rs value)
opb  out  DATA_W  operand B (rt value)
imm  out  DATA_W  extended immediate
use_imm  out  1  ALU uses imm in place of opb
reg_write  out  1  micro-op writes a register
dest  out  REG_AW  destination register
mem_rd  out  1  lw
mem_wr  out  1  sw
branch  out  1  beq
illegal  out  1  unrecognised opcode/funct

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - All registered outputs go to 0, including out_valid.
  - The busy scoreboard is cleared.
  - Reset overrides an in-flight handshake; a micro-op held at reset is discarded.
- Decode, combinational on instr:
  - R-type (opcode 0): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; dest=rd=instr[15:11]; reg_write=1; use_imm=0.
  - addi 0x08: ADD, sign-extended imm.
  - andi 0x0C: AND, zero-extended imm.
  - ori 0x0D: OR, zero-extended imm.
  - addi/andi/ori all use dest=rt, reg_write=1, use_imm=1.
  - lw 0x23: ADD, sign-extended imm, dest=rt, reg_write=1, mem_rd=1.
  - sw 0x2B: ADD, sign-extended imm, mem_wr=1, reg_write=0. Reads rt.
  - beq 0x04: SUB, use_imm=0, branch=1, sign-extended imm, reg_write=0. Reads rt.
  - Any other opcode/funct: alu_op=NOP, reg_write=0, illegal=1. The micro-op is still issued.
  - dest==0 forces reg_write=0.
- Source usage:
  - rs is used by all legal instructions.
  - rt is used by R-type, sw and beq.
  - Register 0 is never busy and always reads 0, regardless of rd_data or bypass.
- Operand bypass: if wb_valid && wb_dest==source && source!=0, the operand takes wb_data; otherwise it takes rd_data1/rd_data2.
- Hazard: hazard=1 when a used source is busy and is not being written back this cycle (bypass satisfies it).
- instr_ready = (!out_valid || ex_ready) && !hazard && !reset.
- Accept when instr_valid && instr_ready. On the next edge:
  - The output register loads the decoded micro-op and out_valid=1.
  - busy[dest] is set if reg_write.
- Output hold:
  - Holding: out_valid && !ex_ready means all outputs stay stable.
  - Draining: ex_ready && no accept means out_valid goes to 0.
  - Throughput is 1 instruction/cycle; latency is 1 cycle from accept to out_valid.
- Scoreboard:
  - wb_valid clears busy[wb_dest].
  - If the same register is set by an issue and cleared by a write-back in the same cycle, the set wins.
  - A write-back to a non-busy register is harmless.
  - wb_dest==0 is ignored.
- rs_addr and rt_addr are pure field slices of instr, valid even when instr_valid=0.

Test Plan:
- Reset with out_valid=1 mid-hold → next cycle out_valid=0, busy all 0, instr_ready=1 with ex_ready=1.
- addi $8,$0,-5 (0x2008FFFB), ex_ready=1 → 1 cycle later out_valid=1, alu_op=1, imm=0xFFFFFFFB, use_imm=1, dest=8, reg_write=1.
- add $9,$8,$8 issued directly after addi $8, with no wb → instr_ready=0 held. Then pulse wb_valid, wb_dest=8, wb_data=7 → accepted that cycle, opa=opb=7.
- ori $10,$0,0x8000 → imm=0x00008000. lw $11,4($8) → mem_rd=1, imm=4, dest=11.
- ex_ready=0 for 3 cycles with out_valid=1 and new instr_valid=1 → outputs stable, instr_ready=0. ex_ready=1 → next micro-op issued in the following cycle, no loss or duplication.
- opcode 0x3F → illegal=1, alu_op=0, reg_write=0, no busy bit set. add $0,$1,$2 → reg_write=0.
